// File: rtl/apb_slave_regfile.sv
// APB slave register file: DEPTH x DATA_W registers with 0..3 programmable wait states.
// The setup phase is decoded in IDLE/DONE. SETUP holds the first access cycle of a transfer that has wait states.
module apb_slave_regfile #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   input  logic [1:0]        wait_cfg,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              setup_phase;
   logic              in_range;
   logic              enter_done;
   logic [IDX_W-1:0]  idx;

   assign setup_phase = PSEL && !PENABLE;
   assign in_range    = int'(PADDR) < DEPTH;
   assign idx         = PADDR[IDX_W-1:0];
   assign enter_done  = (state_nxt == DONE);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE, DONE: begin
            if (setup_phase) begin
               // wait_cfg is sampled only here and is then held in cnt for the whole transfer.
               if (wait_cfg == 2'd0) begin
                  state_nxt = DONE;
                  cnt_nxt   = 2'd0;
               end else begin
                  state_nxt = SETUP;
                  cnt_nxt   = wait_cfg;
               end
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = 2'd0;
            end
         end
         SETUP, WAIT: begin
            if (!PSEL) begin
               state_nxt = IDLE;
               cnt_nxt   = 2'd0;
            end else if (PENABLE) begin
               if (cnt == 2'd1) begin
                  state_nxt = DONE;
                  cnt_nxt   = 2'd0;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = cnt - 2'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         PREADY  <= enter_done;
         PSLVERR <= enter_done && !in_range;
         PRDATA  <= (enter_done && !PWRITE && in_range) ? regs[idx] : '0;
      end
   end

   // NOTE: the register array must clear on reset, so it lives in flops rather than a RAM macro.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (state == DONE && PWRITE && in_range) begin
         regs[idx] <= PWDATA;
      end
   end

endmodule
